// File: rtl/sha2_pkg.sv
// Shared constants and bit functions for the SHA-256/224 compression engine:
// round constants, initial hash values, the state encoding and the working-variable struct.
package sha2_pkg;

  localparam logic [1:0] SHA2_ST_IDLE = 2'd0;
  localparam logic [1:0] SHA2_ST_COMP = 2'd1;
  localparam logic [1:0] SHA2_ST_FIN  = 2'd2;
  localparam logic [1:0] SHA2_ST_OUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = SHA2_ST_IDLE,
    ST_COMP = SHA2_ST_COMP,
    ST_FIN  = SHA2_ST_FIN,
    ST_OUT  = SHA2_ST_OUT
  } sha2_state_e;

  // a occupies the top word so the struct lines up with {H0..H7}
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } sha2_work_t;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] SHA224_IV = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] SHA2_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Word-wise modulo-2^32 addition of two {H0..H7} vectors.
  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return s;
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One purely combinational SHA-2 compression round: a..h, K[t] and W_t in, next a..h out.
module sha2_round
  import sha2_pkg::*;
(
  input  sha2_work_t  cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output sha2_work_t  nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1    = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    t2    = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt.a = t1 + t2;
    nxt.b = cur.a;
    nxt.c = cur.b;
    nxt.d = cur.c;
    nxt.e = cur.d + t1;
    nxt.f = cur.e;
    nxt.g = cur.f;
    nxt.h = cur.g;
  end

endmodule

// File: rtl/sha2_stream_core.sv
// SHA-256/224 block compression engine with internal multi-block chaining,
// RPC rounds per clock and a 16-word rolling message schedule.
module sha2_stream_core
  import sha2_pkg::*;
#(
  parameter int unsigned RPC       = 1,
  parameter bit          EN_SHA224 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         in_mode,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_out,
  output logic         busy
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
    $error("sha2_stream_core: RPC must be 1, 2 or 4");
  end

  sha2_state_e           state_q, state_d;
  logic [6:0]            t_q, t_d;
  logic                  last_q, last_d;
  logic                  mode_q, mode_d;
  logic                  dig_valid_q, dig_valid_d;
  logic [255:0]          h_q, h_d;
  logic [255:0]          dig_q, dig_d;
  sha2_work_t            work_q, work_d;
  logic [15:0][31:0]     win_q, win_d, win_load;
  logic [RPC+15:0][31:0] ext_w;
  sha2_work_t            round_out;
  logic [255:0]          h_sum;
  logic [255:0]          iv_sel;
  logic                  mode_sel;

  // Window entry 0 is always W_t; each cycle appends W_{t+16}..W_{t+15+RPC},
  // later entries feeding on earlier ones from the same cycle.
  function automatic logic [RPC+15:0][31:0] extend_window(input logic [15:0][31:0] win);
    logic [RPC+15:0][31:0] ext;
    ext[15:0] = win;
    for (int j = 0; j < RPC; j++)
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
    return ext;
  endfunction

  assign ext_w = extend_window(win_q);

  always_comb begin
    for (int i = 0; i < 16; i++) win_load[i] = in_block[511 - 32*i -: 32];
  end

  for (genvar i = 0; i < RPC; i++) begin : g_rnd
    sha2_work_t cur;
    sha2_work_t nxt;
    logic [5:0] k_idx;
    assign k_idx = t_q[5:0] + 6'(i);
    if (i == 0) begin : g_head
      assign cur = work_q;
    end else begin : g_link
      assign cur = g_rnd[i-1].nxt;
    end
    sha2_round u_round (
      .cur (cur),
      .k   (SHA2_K[k_idx]),
      .w   (ext_w[i]),
      .nxt (nxt)
    );
  end

  assign round_out = g_rnd[RPC-1].nxt;
  assign h_sum     = add_words(h_q, work_q);
  assign mode_sel  = EN_SHA224 & in_mode;
  assign iv_sel    = mode_sel ? SHA224_IV : SHA256_IV;

  // Handshakes: a block transfers on a clock edge where in_valid & in_ready,
  // a digest where dig_valid & dig_ready; dig_valid/dig_out never change while waiting.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    last_d      = last_q;
    mode_d      = mode_q;
    h_d         = h_q;
    work_d      = work_q;
    win_d       = win_q;
    dig_d       = dig_q;
    dig_valid_d = dig_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          win_d   = win_load;
          last_d  = in_last;
          t_d     = '0;
          state_d = ST_COMP;
          if (in_first) begin
            h_d    = iv_sel;
            work_d = iv_sel;
            mode_d = mode_sel;
          end else begin
            work_d = h_q;
          end
        end
      end
      ST_COMP: begin
        work_d = round_out;
        win_d  = ext_w[RPC+15:RPC];
        t_d    = t_q + 7'(RPC);
        if (t_q + 7'(RPC) == 7'd64) state_d = ST_FIN;
      end
      ST_FIN: begin
        h_d = h_sum;
        if (last_q) begin
          dig_d       = mode_q ? {h_sum[255:32], 32'h0} : h_sum;
          dig_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (dig_ready) begin
          dig_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      last_q      <= 1'b0;
      mode_q      <= 1'b0;
      dig_valid_q <= 1'b0;
      h_q         <= SHA256_IV;
      dig_q       <= '0;
      work_q      <= '0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
      dig_valid_q <= dig_valid_d;
      h_q         <= h_d;
      dig_q       <= dig_d;
      work_q      <= work_d;
      win_q       <= win_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign dig_valid = dig_valid_q;
  assign dig_out   = dig_q;

endmodule

// File: tb/tb_sha2_stream_core.sv
// Self-checking bench for sha2_stream_core: a straight-line SHA-256 reference model and
// a cycle-level expectation of the handshakes, plus known-answer digests.
module tb_sha2_stream_core;

  localparam int unsigned RPC = 4;
  localparam int N_COMP = 64 / RPC;
  localparam int LAT    = N_COMP + 2;

  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [447:0] MSG448    = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
  localparam logic [511:0] BLK_ABC   = {24'h616263, 8'h80, 416'h0, 64'd24};
  localparam logic [511:0] BLK_EMPTY = {8'h80, 440'h0, 64'd0};
  localparam logic [511:0] BLK_M1    = {MSG448, 8'h80, 56'h0};
  localparam logic [511:0] BLK_M2    = {448'h0, 64'd448};

  localparam logic [255:0] D_ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] D_448    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  // ---------------- clock / reset and DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid, in_ready, in_first, in_last, in_mode;
  logic [511:0] in_block;
  logic         dig_valid, dig_ready, busy;
  logic [255:0] dig_out;

  always #5 clk = ~clk;

  sha2_stream_core #(.RPC(RPC), .EN_SHA224(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_out   (dig_out),
    .busy      (busy)
  );

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [255:0] sha256_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, s0, s1, chv, mj;
    logic [255:0] hout;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      s1  = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
      t1  = v[7] + s1 + chv + TK[t] + w[t];
      s0  = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t2  = s0 + mj;
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return hout;
  endfunction

  // ---------------- scoreboard and per-cycle compare ----------------
  logic [255:0] exp_q[$];
  int           acc_log[$];
  logic [255:0] mdl_h       = IV256;
  bit           mdl_mode    = 1'b0;
  bit           mdl_last    = 1'b0;
  int           busy_left   = 0;
  bit           dig_pending = 1'b0;
  bit           dig_zero    = 1'b1;
  bit           dv_prev     = 1'b0;
  int           cyc         = 0;
  int           acc_cyc     = 0;
  int           last_lat    = -1;

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      check_int("in_ready", int'(in_ready), int'(busy_left == 0 && !dig_pending));
      check_int("busy", int'(busy), int'(busy_left != 0 || dig_pending));
      check_int("dig_valid", int'(dig_valid), int'(dig_pending));
      if (dig_pending)
        check256("dig_out", dig_out, (exp_q.size() != 0) ? exp_q[0] : '0);
      else if (dig_zero)
        check256("dig_out_after_reset", dig_out, '0);
      if (dig_valid && !dv_prev) last_lat = cyc - acc_cyc;
      dv_prev = dig_valid;
      if (in_valid && in_ready && !rst) begin
        acc_cyc = cyc;
        acc_log.push_back(cyc);
      end
      if (rst) begin
        mdl_h       = IV256;
        mdl_mode    = 1'b0;
        busy_left   = 0;
        dig_pending = 1'b0;
        dig_zero    = 1'b1;
        exp_q.delete();
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0 && mdl_last) begin
          dig_pending = 1'b1;
          dig_zero    = 1'b0;
        end
      end else if (dig_pending) begin
        if (dig_ready) begin
          dig_pending = 1'b0;
          void'(exp_q.pop_front());
        end
      end else if (in_valid) begin
        if (in_first) begin
          mdl_h    = in_mode ? IV224 : IV256;
          mdl_mode = in_mode;
        end
        mdl_h = sha256_compress(mdl_h, in_block);
        if (in_last) exp_q.push_back(mdl_mode ? {mdl_h[255:32], 32'h0} : mdl_h);
        mdl_last  = in_last;
        busy_left = N_COMP + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_block(input logic [511:0] blk, input logic first, input logic last, input logic mode);
    int   tries = 0;
    logic took  = 1'b0;
    in_valid = 1'b1;
    in_block = blk;
    in_first = first;
    in_last  = last;
    in_mode  = mode;
    while (!took && tries < 200) begin
      @(negedge clk);
      took = in_ready;
      tries++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_int("block_accepted", int'(took), 1);
  endtask

  task automatic wait_digest(input string name, input logic [255:0] lit);
    int   tries = 0;
    logic got   = 1'b0;
    while (!got && tries < 200) begin
      @(negedge clk);
      got = dig_valid;
      tries++;
      if (got) check256(name, dig_out, lit);
      @(posedge clk);
      #1;
    end
    check_int({name, "_seen"}, int'(got), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [255:0] held;
    int           gap;
    logic         got;
    in_valid  = 1'b0;
    in_block  = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_mode   = 1'b0;
    dig_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_int("reset_in_ready", int'(in_ready), 1);
    check_int("reset_dig_valid", int'(dig_valid), 0);
    check_int("reset_busy", int'(busy), 0);
    check256("reset_dig_out", dig_out, '0);
    @(posedge clk);
    #1;

    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0);
    wait_digest("abc_sha256", D_ABC256);
    check_int("abc_sha256_latency", last_lat, LAT);

    send_block(BLK_EMPTY, 1'b1, 1'b1, 1'b0);
    wait_digest("empty_sha256", D_EMPTY);
    check_int("empty_latency", last_lat, LAT);

    send_block(BLK_ABC, 1'b1, 1'b1, 1'b1);
    wait_digest("abc_sha224", D_ABC224);
    check_int("abc_sha224_latency", last_lat, LAT);

    // two-block message, mode raised on the second block must be ignored
    acc_log.delete();
    send_block(BLK_M1, 1'b1, 1'b0, 1'b0);
    send_block(BLK_M2, 1'b0, 1'b1, 1'b1);
    wait_digest("two_block", D_448);
    gap = (acc_log.size() >= 2) ? acc_log[1] - acc_log[0] : -1;
    check_int("two_block_gap", gap, LAT);
    check_int("two_block_latency", last_lat, LAT);

    // output backpressure with a competing block offered
    dig_ready = 1'b0;
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = dig_valid;
      @(posedge clk);
      #1;
    end
    check_int("hold_seen", int'(got), 1);
    held     = dig_out;
    check256("hold_first", held, D_ABC256);
    in_valid = 1'b1;
    in_block = BLK_EMPTY;
    in_first = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_int("hold_valid", int'(dig_valid), 1);
      check256("hold_out", dig_out, D_ABC256);
      check_int("hold_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    dig_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_int("release_dig_valid", int'(dig_valid), 0);
    check_int("release_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // reset around round 30 of a block
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_int("midrst_in_ready", int'(in_ready), 1);
    check_int("midrst_dig_valid", int'(dig_valid), 0);
    check_int("midrst_busy", int'(busy), 0);
    @(posedge clk);
    #1;

    // non-first block straight after reset chains from the SHA-256 IV
    send_block(BLK_ABC, 1'b0, 1'b1, 1'b0);
    wait_digest("post_reset_chain", D_ABC256);
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0);
    wait_digest("post_reset_abc", D_ABC256);

    // a first block in the middle of a chain restarts it
    send_block(BLK_M1, 1'b1, 1'b0, 1'b0);
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0);
    wait_digest("chain_restart", D_ABC256);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
